// File: rtl/ttsweep_pkg.sv
// Shared types and helpers for the truth-table sweeper.
// Row-to-bit mapping follows the Cello hex encoding (row 0 in the MSB).
package ttsweep_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    DONE
  } state_t;

  localparam int ROWS = 8;

  function automatic logic [2:0] row_bit(input logic [2:0] r);
    return 3'(ROWS - 1) - r;
  endfunction

endpackage

// File: rtl/truth_table_sweeper.sv
// Walks all 8 rows of a 3-input circuit, samples its output after a
// settle window and grades the observed truth table against a hex code.
module truth_table_sweeper
  import ttsweep_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] expected,
  output logic       in1,
  output logic       in2,
  output logic       in3,
  input  logic       dut_out,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] observed,
  output logic [3:0] mismatches,
  output logic [2:0] first_fail_row
);

  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255) begin : g_bad_settle
    $error("SETTLE_CYCLES must be in 1..255");
  end

  localparam logic [7:0] LAST = 8'(SETTLE_CYCLES - 1);

  state_t     state;
  logic [7:0] expected_q;
  logic [7:0] cnt;
  logic [2:0] row;

  logic       sample;
  logic       miss;
  logic [3:0] mism_next;

  assign sample    = (cnt == LAST);
  assign miss      = (dut_out != expected_q[row_bit(row)]);
  assign mism_next = mismatches + {3'b000, miss};

  // Sweep FSM: row sequencing, sampling and grading, all outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      expected_q     <= 8'h00;
      cnt            <= 8'h00;
      row            <= 3'd0;
      in1            <= 1'b0;
      in2            <= 1'b0;
      in3            <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      observed       <= 8'h00;
      mismatches     <= 4'd0;
      first_fail_row <= 3'd0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            expected_q      <= expected;
            observed        <= 8'h00;
            mismatches      <= 4'd0;
            first_fail_row  <= 3'd0;
            pass            <= 1'b0;
            row             <= 3'd0;
            cnt             <= 8'h00;
            {in1, in2, in3} <= 3'd0;
            busy            <= 1'b1;
            state           <= SETTLE;
          end
        end
        SETTLE: begin
          cnt <= cnt + 8'd1;
          if (sample) begin
            cnt                     <= 8'h00;
            observed[row_bit(row)]  <= dut_out;
            mismatches              <= mism_next;
            if (miss && mismatches == 4'd0)
              first_fail_row <= row;
            if (row == 3'(ROWS - 1)) begin
              state           <= DONE;
              busy            <= 1'b0;
              done            <= 1'b1;
              pass            <= (mism_next == 4'd0);
              {in1, in2, in3} <= 3'd0;
            end else begin
              row             <= row + 3'd1;
              {in1, in2, in3} <= row + 3'd1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: circuit models drive dut_out and a
// row-level reference model predicts table, mismatch count and first row.
module tb_truth_table_sweeper;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic       start_a = 1'b0;
  logic [7:0] exp_a   = 8'h00;
  logic       a_in1, a_in2, a_in3, dout_a;
  logic       busy_a, done_a, pass_a;
  logic [7:0] obs_a;
  logic [3:0] mm_a;
  logic [2:0] ffr_a;
  int         mode_a = 0;
  logic [7:0] tbl_a  = 8'h00;

  logic       start_b = 1'b0;
  logic [7:0] exp_b   = 8'h00;
  logic       b_in1, b_in2, b_in3, dout_b;
  logic       busy_b, done_b, pass_b;
  logic [7:0] obs_b;
  logic [3:0] mm_b;
  logic [2:0] ffr_b;
  int         mode_b = 0;
  logic [7:0] tbl_b  = 8'h00;

  // mode 0: 0xC7 NOR/NOT netlist, 1: stuck-at-0, 2: inverted netlist,
  // otherwise: arbitrary function given as a Cello hex table
  function automatic logic circuit(int mode, logic [7:0] tbl,
                                   logic a, logic b, logic c);
    logic g;
    int   r;
    g = ~(a & ~b & ~c) & ~(b & ~a);
    r = 4 * int'(a) + 2 * int'(b) + int'(c);
    case (mode)
      0:       return g;
      1:       return 1'b0;
      2:       return ~g;
      default: return tbl[7 - r];
    endcase
  endfunction

  assign dout_a = circuit(mode_a, tbl_a, a_in1, a_in2, a_in3);
  assign dout_b = circuit(mode_b, tbl_b, b_in1, b_in2, b_in3);

  truth_table_sweeper #(.SETTLE_CYCLES(2)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .expected(exp_a),
    .in1(a_in1), .in2(a_in2), .in3(a_in3), .dut_out(dout_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .observed(obs_a),
    .mismatches(mm_a), .first_fail_row(ffr_a)
  );

  truth_table_sweeper #(.SETTLE_CYCLES(1)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .expected(exp_b),
    .in1(b_in1), .in2(b_in2), .in3(b_in3), .dut_out(dout_b),
    .busy(busy_b), .done(done_b), .pass(pass_b), .observed(obs_b),
    .mismatches(mm_b), .first_fail_row(ffr_b)
  );

  task automatic chk(string tag, logic [31:0] got, logic [31:0] want);
    tests++;
    assert (got === want) else begin
      fails++;
      $error("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  function automatic void model(int mode, logic [7:0] tbl, logic [7:0] e,
                                output logic [7:0] o, output logic [3:0] m,
                                output logic [2:0] f);
    logic a, b, c;
    o = 8'h00;
    m = 4'd0;
    f = 3'd0;
    for (int r = 0; r < 8; r++) begin
      {a, b, c} = 3'(r);
      o[7 - r] = circuit(mode, tbl, a, b, c);
    end
    for (int r = 7; r >= 0; r--)
      if (o[7 - r] != e[7 - r]) begin
        m = m + 4'd1;
        f = 3'(r);
      end
  endfunction

  task automatic sweep_a(string tag, logic [7:0] e, int mode,
                         logic [7:0] tbl, bit disturb, bit do_rst);
    logic [7:0] o;
    logic [3:0] m;
    logic [2:0] f;
    int  n;
    int  extra;
    bit  got;
    bit  hit;
    mode_a = mode;
    tbl_a  = tbl;
    model(mode, tbl, e, o, m, f);
    exp_a   = e;
    start_a = 1'b1;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    chk({tag, ".busy_t0"}, 32'(busy_a), 32'd1);
    chk({tag, ".row0"}, 32'({a_in1, a_in2, a_in3}), 32'd0);
    n   = 0;
    got = 1'b0;
    hit = 1'b0;
    while (n < 100 && !got && !hit) begin
      @(posedge clk);
      #1;
      n++;
      if (disturb) begin
        start_a = (n == 5);
        if (n == 5) exp_a = 8'h00;
      end
      if (do_rst && {a_in1, a_in2, a_in3} == 3'd4) begin
        #1 rst = 1'b1;
        #1;
        chk({tag, ".rst_zero"},
            32'({a_in1, a_in2, a_in3, busy_a, done_a, pass_a,
                 obs_a, mm_a, ffr_a}), 32'd0);
        rst = 1'b0;
        hit = 1'b1;
      end
      got = done_a;
    end
    if (do_rst) begin
      chk({tag, ".rst_reached"}, 32'(hit), 32'd1);
    end else begin
      chk({tag, ".latency"}, n, 16);
      chk({tag, ".observed"}, 32'(obs_a), 32'(o));
      chk({tag, ".mismatches"}, 32'(mm_a), 32'(m));
      chk({tag, ".first_fail"}, 32'(ffr_a), 32'(f));
      chk({tag, ".pass"}, 32'(pass_a), 32'(m == 4'd0));
      chk({tag, ".busy_done"}, 32'(busy_a), 32'd0);
      @(posedge clk);
      #1;
      chk({tag, ".done_1cyc"}, 32'(done_a), 32'd0);
      chk({tag, ".pass_held"}, 32'(pass_a), 32'(m == 4'd0));
      if (disturb) begin
        start_a = 1'b0;
        extra   = 0;
        for (int i = 0; i < 20; i++) begin
          @(posedge clk);
          #1;
          if (done_a || busy_a) extra++;
        end
        chk({tag, ".no_requeue"}, extra, 0);
      end
    end
  endtask

  task automatic wait_done_b(output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!done_b && n < 100);
  endtask

  task automatic b2b(string tag, logic [7:0] e, int mode, logic [7:0] tbl);
    logic [7:0] o;
    logic [3:0] m;
    logic [2:0] f;
    int n;
    mode_b = mode;
    tbl_b  = tbl;
    model(mode, tbl, e, o, m, f);
    exp_b   = e;
    start_b = 1'b1;
    @(posedge clk);
    #1;
    wait_done_b(n);
    chk({tag, ".latency"}, n, 8);
    chk({tag, ".observed1"}, 32'(obs_b), 32'(o));
    chk({tag, ".mismatches1"}, 32'(mm_b), 32'(m));
    chk({tag, ".first_fail1"}, 32'(ffr_b), 32'(f));
    chk({tag, ".pass1"}, 32'(pass_b), 32'(m == 4'd0));
    wait_done_b(n);
    start_b = 1'b0;
    chk({tag, ".period"}, n, 10);
    chk({tag, ".observed2"}, 32'(obs_b), 32'(o));
    chk({tag, ".mismatches2"}, 32'(mm_b), 32'(m));
    chk({tag, ".pass2"}, 32'(pass_b), 32'(m == 4'd0));
    repeat (12) @(posedge clk);
    #1;
  endtask

  initial begin
    #2;
    chk("reset_a",
        32'({a_in1, a_in2, a_in3, busy_a, done_a, pass_a, obs_a, mm_a, ffr_a}),
        32'd0);
    chk("reset_b",
        32'({b_in1, b_in2, b_in3, busy_b, done_b, pass_b, obs_b, mm_b, ffr_b}),
        32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    sweep_a("golden", 8'hC7, 0, 8'h00, 1'b0, 1'b0);
    sweep_a("stuck0", 8'hC7, 1, 8'h00, 1'b0, 1'b0);
    sweep_a("invert", 8'hC7, 2, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++)
      sweep_a($sformatf("rand%0d", i), 8'($urandom),
              int'($urandom_range(0, 3)), 8'($urandom), 1'b0, 1'b0);
    sweep_a("busy_start", 8'hC7, 0, 8'h00, 1'b1, 1'b0);
    sweep_a("rst_mid", 8'hC7, 0, 8'h00, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    sweep_a("after_rst", 8'hC7, 0, 8'h00, 1'b0, 1'b0);

    b2b("b2b_golden", 8'hC7, 0, 8'h00);
    b2b("b2b_rand", 8'($urandom), 3, 8'($urandom));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
